bip_exec_sequencer: RTL

- Control unit that sequences the BIP datapath: fetches instructions from synchronous program memory, holds the PC and instruction register, and feeds the opcode to the instruction decoder.
- Qualifies the decoder's write strobes with a one-cycle execute enable, and stops on HALT or an illegal opcode.
- Supports continuous run and single-step under host (debug/UART) command, and counts executed instructions for host readout.

---
 rtl/bip_pkg.sv | 33 +++
 rtl/bip_program_counter.sv | 23 ++
 rtl/bip_exec_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bip_pkg.sv
// Shared BIP definitions: opcode constants, sequencer state/mode encodings and default widths.
// Pure declarations; no logic, no latency, no flow control.
package bip_pkg;

    localparam int NB_OPCODE_DEF  = 5;
    localparam int NB_OPERAND_DEF = 11;
    localparam int NB_INSTR_DEF   = NB_OPCODE_DEF + NB_OPERAND_DEF;
    localparam int NB_ADDR_DEF    = 11;
    localparam int NB_CYCLES_DEF  = 16;

    localparam logic [NB_OPCODE_DEF-1:0] OPC_HALT = 5'b00000;
    localparam logic [NB_OPCODE_DEF-1:0] OPC_STO  = 5'b00001;
    localparam logic [NB_OPCODE_DEF-1:0] OPC_LD   = 5'b00010;
    localparam logic [NB_OPCODE_DEF-1:0] OPC_LDI  = 5'b00011;
    localparam logic [NB_OPCODE_DEF-1:0] OPC_ADD  = 5'b00100;
    localparam logic [NB_OPCODE_DEF-1:0] OPC_ADDI = 5'b00101;
    localparam logic [NB_OPCODE_DEF-1:0] OPC_SUB  = 5'b00110;
    localparam logic [NB_OPCODE_DEF-1:0] OPC_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_STEP = 1'b1
    } mode_t;

endpackage

// File: rtl/bip_program_counter.sv
// Program counter: synchronous clear, +1 on increment enable, natural wrap at 2^NB_ADDR.
// Update visible one cycle after i_inc/i_clear; no flow control (clear has priority).
module bip_program_counter #(
    parameter int NB_ADDR = 11
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_inc,
    output logic [NB_ADDR-1:0] o_pc
);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_pc <= '0;
        end else if (i_clear) begin
            o_pc <= '0;
        end else if (i_inc) begin
            o_pc <= o_pc + NB_ADDR'(1);
        end
    end

endmodule

// File: rtl/bip_exec_sequencer.sv
// BIP control unit: FETCH/LOAD/EXEC sequencing, 3 cycles per instruction, run or single-step.
// Host run/step pulses are dropped while busy or halted; i_clear aborts and restarts from PC 0.
module bip_exec_sequencer
    import bip_pkg::*;
#(
    parameter int NB_OPCODE  = 5,
    parameter int NB_OPERAND = 11,
    parameter int NB_INSTR   = 16,
    parameter int NB_ADDR    = 11,
    parameter int NB_CYCLES  = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_run,
    input  logic                  i_step,
    input  logic                  i_clear,
    output logic [NB_ADDR-1:0]    o_pm_addr,
    output logic                  o_pm_rd,
    input  logic [NB_INSTR-1:0]   i_pm_data,
    output logic [NB_OPCODE-1:0]  o_opcode,
    output logic [NB_OPERAND-1:0] o_operand,
    input  logic                  i_wr_PC,
    output logic                  o_exec_en,
    output logic [NB_ADDR-1:0]    o_pc,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic                  o_illegal,
    output logic                  o_done,
    output logic [NB_CYCLES-1:0]  o_cycles
);

    state_t                state, state_next;
    mode_t                 mode, mode_next;
    logic [NB_INSTR-1:0]   ir;
    logic [NB_CYCLES-1:0]  cycles;
    logic                  illegal;
    logic                  done;
    logic                  is_halt;
    logic                  exec_ok;
    logic                  count_inc;
    logic                  set_illegal;
    logic                  load_ir;
    logic [NB_ADDR-1:0]    pc;

    assign is_halt = (ir[NB_INSTR-1 -: NB_OPCODE] == '0);

    always_comb begin
        state_next  = state;
        mode_next   = mode;
        exec_ok     = 1'b0;
        count_inc   = 1'b0;
        set_illegal = 1'b0;
        load_ir     = 1'b0;
        if (i_clear) begin
            state_next = ST_IDLE;
            mode_next  = MODE_RUN;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_run) begin
                        state_next = ST_FETCH;
                        mode_next  = MODE_RUN;
                    end else if (i_step) begin
                        state_next = ST_FETCH;
                        mode_next  = MODE_STEP;
                    end
                end
                ST_FETCH: state_next = ST_LOAD;
                ST_LOAD: begin
                    load_ir    = 1'b1;
                    state_next = ST_EXEC;
                end
                ST_EXEC: begin
                    // The decoder drops wr_PC for any opcode it does not know.
                    if (is_halt) begin
                        count_inc  = 1'b1;
                        state_next = ST_HALTED;
                    end else if (!i_wr_PC) begin
                        set_illegal = 1'b1;
                        state_next  = ST_HALTED;
                    end else begin
                        exec_ok    = 1'b1;
                        count_inc  = 1'b1;
                        state_next = (mode == MODE_RUN) ? ST_FETCH : ST_IDLE;
                    end
                end
                ST_HALTED: state_next = ST_HALTED;
                default:   state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            mode    <= MODE_RUN;
            ir      <= '0;
            cycles  <= '0;
            illegal <= 1'b0;
            done    <= 1'b0;
        end else begin
            state <= state_next;
            mode  <= mode_next;
            done  <= exec_ok && (mode == MODE_STEP);
            if (i_clear) begin
                ir      <= '0;
                cycles  <= '0;
                illegal <= 1'b0;
            end else begin
                if (load_ir) begin
                    ir <= i_pm_data;
                end
                if (count_inc && (cycles != '1)) begin
                    cycles <= cycles + NB_CYCLES'(1);
                end
                if (set_illegal) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

    bip_program_counter #(
        .NB_ADDR (NB_ADDR)
    ) u_pc (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (i_clear),
        .i_inc   (exec_ok),
        .o_pc    (pc)
    );

    assign o_pm_addr = pc;
    assign o_pm_rd   = (state == ST_FETCH);
    assign o_opcode  = ir[NB_INSTR-1 -: NB_OPCODE];
    assign o_operand = ir[NB_OPERAND-1:0];
    assign o_exec_en = exec_ok;
    assign o_pc      = pc;
    assign o_busy    = (state == ST_FETCH) || (state == ST_LOAD) || (state == ST_EXEC);
    assign o_halted  = (state == ST_HALTED);
    assign o_illegal = illegal;
    assign o_done    = done;
    assign o_cycles  = cycles;

endmodule
